// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register countdown scoreboard that resolves RAW and WAW hazards
//   against in-flight results of arbitrary latency (up to MAX_LAT). It also
//   owns branch-redirect flushing and back-end freeze for the IF/ID and
//   ID/EX pipeline registers.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     When defined, adds the 32-bit stall_cnt_o and flush_cnt_o
//     performance counters.
//
// Ports
//   clk, reset        pipeline clock, asynchronous active-high reset
//   id_valid_i        ID holds a real instruction
//   id_rs1_i/rs2_i    source register indices
//   id_use_rs1_i/rs2  instruction reads the corresponding source
//   id_rd_i, id_wr_i  destination index and write enable
//   id_lat_i          stall cycles a dependent consumer needs (clamped to MAX_LAT)
//   redirect_i        EX resolved a taken or mispredicted branch
//   backend_busy_i    MEM/EX cannot advance
//   if_id_stall_o     hold PC and IF_ID
//   if_id_flush_o     bubble IF_ID
//   id_ex_stall_o     hold ID_EX
//   id_ex_flush_o     bubble ID_EX
//   issue_o           ID instruction advances into EX this cycle
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 7,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wr_i,
  input  logic [CNT_W-1:0]  id_lat_i,
  input  logic              redirect_i,
  input  logic              backend_busy_i,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  output logic              if_id_stall_o,
  output logic              if_id_flush_o,
  output logic              id_ex_stall_o,
  output logic              id_ex_flush_o,
  output logic              issue_o
);

  localparam int NREG = 1 << REG_AW;

  // Remaining cycles until each register's pending result is forwardable.
  logic [CNT_W-1:0] cnt [NREG];

  logic [CNT_W-1:0] lat_eff;
  logic             raw;
  logic             waw;
  logic             hz;
  logic             freeze;

  function automatic logic [CNT_W-1:0] clamp_lat(input logic [CNT_W-1:0] lat);
    return (lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : lat;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign lat_eff = clamp_lat(id_lat_i);

  // Index 0 is hardwired to zero, so lookups of x0 never report a hazard.
  assign raw = id_valid_i &
               ((id_use_rs1_i & (cnt[id_rs1_i] != '0)) |
                (id_use_rs2_i & (cnt[id_rs2_i] != '0)));

  // A younger write must not land before an older one still in flight.
  assign waw = id_valid_i & id_wr_i & (id_rd_i != '0) & (cnt[id_rd_i] > lat_eff);

  assign hz = raw | waw;

  // Redirect outranks busy: the branch is resolved, so counters keep draining.
  assign freeze = backend_busy_i & ~redirect_i;

  always_comb begin
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_stall_o = 1'b0;
    id_ex_flush_o = 1'b0;
    issue_o       = 1'b0;
    if (redirect_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (backend_busy_i) begin
      if_id_stall_o = 1'b1;
      id_ex_stall_o = 1'b1;
    end else if (hz) begin
      if_id_stall_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      issue_o = id_valid_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (!freeze) begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (issue_o && id_wr_i && (id_rd_i == REG_AW'(r)))
          cnt[r] <= lat_eff;
        else
          cnt[r] <= sat_dec(cnt[r]);
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hz && !redirect_i && !backend_busy_i) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (redirect_i)                           flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs1_i = '0;
  logic [4:0] id_rs2_i = '0;
  logic       id_use_rs1_i = 1'b0;
  logic       id_use_rs2_i = 1'b0;
  logic [4:0] id_rd_i = '0;
  logic       id_wr_i = 1'b0;
  logic [2:0] id_lat_i = '0;
  logic       redirect_i = 1'b0;
  logic       backend_busy_i = 1'b0;
  logic       if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, issue_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  // {if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, issue}
  localparam logic [4:0] IDLE  = 5'b00000;
  localparam logic [4:0] ISSUE = 5'b00001;
  localparam logic [4:0] HZ    = 5'b10010;
  localparam logic [4:0] REDIR = 5'b01010;
  localparam logic [4:0] BUSY  = 5'b10100;

  logic [4:0] outs;
  assign outs = {if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, issue_o};

  hazard_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid_i     (id_valid_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_use_rs1_i   (id_use_rs1_i),
    .id_use_rs2_i   (id_use_rs2_i),
    .id_rd_i        (id_rd_i),
    .id_wr_i        (id_wr_i),
    .id_lat_i       (id_lat_i),
    .redirect_i     (redirect_i),
    .backend_busy_i (backend_busy_i),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
`endif
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_stall_o  (id_ex_stall_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .issue_o        (issue_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and settle before checking.
  task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic wr, input logic [2:0] lat,
                      input logic redir, input logic busy);
    @(negedge clk);
    id_valid_i     = v;
    id_rs1_i       = rs1;
    id_use_rs1_i   = u1;
    id_rs2_i       = rs2;
    id_use_rs2_i   = u2;
    id_rd_i        = rd;
    id_wr_i        = wr;
    id_lat_i       = lat;
    redirect_i     = redir;
    backend_busy_i = busy;
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_outs", 32'(outs), 32'(IDLE));
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_reset", stall_cnt_o, 32'd0);
`endif

    // Load (lat 1) to x5, then consumer of x5: exactly one stall
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); chk("ld_issue", 32'(outs), 32'(ISSUE));
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); chk("ld_use_stall", 32'(outs), 32'(HZ));
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); chk("ld_use_issue", 32'(outs), 32'(ISSUE));

    // Lat 4 to x7, one unrelated issue, then rs2 consumer: three stalls
    step(1, 0, 0, 0, 0, 7, 1, 4, 0, 0); chk("mul_issue", 32'(outs), 32'(ISSUE));
    step(1, 1, 1, 2, 1, 0, 0, 0, 0, 0); chk("unrelated_issue", 32'(outs), 32'(ISSUE));
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0); chk($sformatf("mul_stall%0d", i), 32'(outs), 32'(HZ));
    end
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0); chk("mul_use_issue", 32'(outs), 32'(ISSUE));
    step(1, 0, 0, 0, 0, 7, 1, 4, 0, 0); chk("mul2_issue", 32'(outs), 32'(ISSUE));
    step(1, 0, 0, 7, 0, 0, 0, 0, 0, 0); chk("no_use_rs2", 32'(outs), 32'(ISSUE));

    // Writes to x0 never mark the scoreboard
    step(1, 0, 0, 0, 0, 0, 1, 5, 0, 0); chk("x0_write", 32'(outs), 32'(ISSUE));
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0); chk("x0_read", 32'(outs), 32'(ISSUE));
    chk("x0_cnt", 32'(dut.cnt[0]), 32'd0);

    // WAW: lat 5 to x3, then lat-0 write to x3 waits until cnt[3] = 0
    step(1, 0, 0, 0, 0, 3, 1, 5, 0, 0); chk("waw_first", 32'(outs), 32'(ISSUE));
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); chk($sformatf("waw_stall%0d", i), 32'(outs), 32'(HZ));
    end
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); chk("waw_issue", 32'(outs), 32'(ISSUE));
    // Longer second write needs no stall and takes over the entry
    step(1, 0, 0, 0, 0, 3, 1, 5, 0, 0); chk("waw_long_first", 32'(outs), 32'(ISSUE));
    step(1, 0, 0, 0, 0, 3, 1, 6, 0, 0); chk("waw_long_second", 32'(outs), 32'(ISSUE));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("waw_cnt3", 32'(dut.cnt[3]), 32'd6);

    // Lat 3 to x10; redirect then backend freeze during the RAW stall
    step(1, 0, 0, 0, 0, 10, 1, 3, 0, 0); chk("l3_issue", 32'(outs), 32'(ISSUE));
    step(1, 10, 1, 0, 0, 0, 0, 0, 0, 0); chk("l3_stall", 32'(outs), 32'(HZ));
    step(1, 10, 1, 0, 0, 0, 0, 0, 1, 0); chk("l3_redirect", 32'(outs), 32'(REDIR));
    step(1, 10, 1, 0, 0, 0, 0, 0, 0, 1); chk("l3_busy0", 32'(outs), 32'(BUSY));
    chk("l3_cnt_busy0", 32'(dut.cnt[10]), 32'd1);
    step(1, 10, 1, 0, 0, 0, 0, 0, 0, 1); chk("l3_busy1", 32'(outs), 32'(BUSY));
    chk("l3_cnt_busy1", 32'(dut.cnt[10]), 32'd1);
    step(1, 10, 1, 0, 0, 0, 0, 0, 0, 0); chk("l3_stall_after_busy", 32'(outs), 32'(HZ));
    chk("l3_cnt_held", 32'(dut.cnt[10]), 32'd1);
    step(1, 10, 1, 0, 0, 0, 0, 0, 0, 0); chk("l3_use_issue", 32'(outs), 32'(ISSUE));
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); chk("redir_over_busy", 32'(outs), 32'(REDIR));
    step(1, 0, 0, 0, 0, 12, 1, 0, 0, 1); chk("busy_no_issue", 32'(outs), 32'(BUSY));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("busy_no_mark", 32'(dut.cnt[12]), 32'd0);

    // Over-range latency: 3-bit port cannot exceed 7, MAX_LAT is 7
    step(1, 0, 0, 0, 0, 11, 1, 7, 0, 0); chk("lat7_issue", 32'(outs), 32'(ISSUE));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("lat7_cnt", 32'(dut.cnt[11]), 32'd7);

    // Lat 4 to x9, reset in the middle of the stall drops it at once
    step(1, 0, 0, 0, 0, 9, 1, 4, 0, 0); chk("rst_lat_issue", 32'(outs), 32'(ISSUE));
    step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); chk("rst_pre_stall", 32'(outs), 32'(HZ));
    chk("rst_pre_cnt9", 32'(dut.cnt[9]), 32'd4);
    #1 reset = 1'b1;
    #1;
    chk("rst_stall_drop", 32'(if_id_stall_o), 32'd0);
    chk("rst_flush_drop", 32'(id_ex_flush_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_after_rst", stall_cnt_o, 32'd0);
    chk("perf_flush_after_rst", flush_cnt_o, 32'd0);
`endif
    step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); chk("rst_use_issue", 32'(outs), 32'(ISSUE));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("final_idle", 32'(outs), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use detector.
- Keeps a per-register countdown scoreboard of in-flight results with arbitrary latency (loads, multi-cycle mul/div), so RAW and WAW hazards of any depth up to MAX_LAT are resolved by stalling IF/ID.
- Also owns branch-redirect flushing and back-end freeze.
- Sits between the ID stage and the IF_ID/ID_EX pipeline registers.

Parameters:
- REG_AW, 5, register index width; the scoreboard holds 2^REG_AW entries.
- MAX_LAT, 7, largest result latency accepted on id_lat_i.
- CNT_W, 3, counter width; must satisfy 2^CNT_W-1 >= MAX_LAT.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i  in  REG_AW  source 1 index.
- id_rs2_i  in  REG_AW  source 2 index.
- id_use_rs1_i  in  1  instruction reads rs1.
- id_use_rs2_i  in  1  instruction reads rs2.
- id_rd_i  in  REG_AW  destination index.
- id_wr_i  in  1  instruction writes rd.
- id_lat_i  in  CNT_W  stall cycles the following dependent instruction needs (0 = ALU/forwardable, 1 = load, N = multi-cycle).
- redirect_i  in  1  EX resolved a taken or mispredicted branch.
- backend_busy_i  in  1  MEM/EX cannot advance (e.g. memory wait).
- if_id_stall_o  out  1  hold PC and IF_ID.
- if_id_flush_o  out  1  bubble IF_ID.
- id_ex_stall_o  out  1  hold ID_EX.
- id_ex_flush_o  out  1  bubble ID_EX.
- issue_o  out  1  ID instruction advances into EX this cycle.

Behaviour:
- State: cnt[r], CNT_W bits, one per register.
- Reset: all cnt = 0, asynchronously. All outputs are combinational and equal 0 while redirect_i = 0, backend_busy_i = 0 and id_valid_i = 0. A reset mid-stall drops the stall in the same cycle.
- Register 0 is never pending. Writes to cnt[0] are ignored, and reads of index 0 never cause a hazard.
- raw = id_valid_i & ((id_use_rs1_i & cnt[rs1] != 0) | (id_use_rs2_i & cnt[rs2] != 0)).
- waw = id_valid_i & id_wr_i & rd != 0 & cnt[rd] > id_lat_i.
- hz = raw | waw.
- Priority 1, redirect_i: if_id_flush_o = 1, id_ex_flush_o = 1, all stalls = 0, issue_o = 0. Redirect overrides hz. backend_busy_i does not override redirect; the EX branch is already resolved.
- Priority 2, backend_busy_i: if_id_stall_o = 1, id_ex_stall_o = 1, flushes = 0, issue_o = 0. Counters freeze and do not decrement.
- Priority 3, hz: if_id_stall_o = 1, id_ex_flush_o = 1 (bubble into EX), issue_o = 0. Counters decrement.
- Otherwise: issue_o = id_valid_i, all other outputs 0.
- Counter update, every non-frozen cycle: each cnt[r] becomes max(cnt[r]-1, 0). Saturates at 0, no wrap-around.
- On issue_o & id_wr_i & rd != 0: cnt[rd] <= id_lat_i. The new value overrides that entry's decrement in the same cycle.
- id_lat_i > MAX_LAT is clamped to MAX_LAT.
- Latency: hazard detection and stall/flush are same-cycle (combinational). The scoreboard update is visible next cycle.
- A load (lat 1) followed by a dependent instruction gives exactly 1 stall cycle. Lat N gives N stall cycles for an immediate consumer, and N-k for a consumer k cycles later.
- A squashed ID instruction never issues, so it never marks the scoreboard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments on each cycle with hz & ~redirect_i & ~backend_busy_i.
  - flush_cnt_o increments on each redirect_i cycle.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: no counters and no such ports; the core behaviour is identical.

Test Plan:
- After reset: issue lat 1 with rd = 5, then a consumer with rs1 = 5 -> exactly 1 cycle of if_id_stall_o = 1 and id_ex_flush_o = 1, then issue_o = 1.
- Issue lat 4 with rd = 7. One unrelated instruction issues. Then a consumer with rs2 = 7 -> 3 stall cycles. The same consumer with id_use_rs2_i = 0 -> no stall.
- rd = 0 with lat 5, then a consumer of x0 -> no stall; cnt[0] stays 0.
- WAW: lat 5 to rd = 3, next instruction writes rd = 3 with lat 0 -> stalls until cnt[3] = 0. With lat 6 instead -> no stall, and cnt[3] = 6.
- During a lat-3 RAW stall, assert redirect_i -> both flushes = 1, stalls = 0, issue_o = 0. Hold backend_busy_i for 2 cycles -> the counter holds its value.
- Assert reset mid-stall with cnt[9] = 4 -> stall drops immediately. After release, a consumer of x9 issues without stall. With HAZARD_PERF_CNT_EN, stall_cnt_o = 0 after reset.
